// File: rtl/bidir_shiftreg_if.sv
// Signal bundle for bidir_shiftreg: control/data inputs and register/serial outputs.
// The master drives OP, d and shift_in; the slave (the register) drives q and the serial taps.
interface bidir_shiftreg_if #(
  parameter int N = 4
);
  logic         shift_in;
  logic [N-1:0] d;
  logic [1:0]   OP;
  logic [N-1:0] q;
  logic         shift_out_left;
  logic         shift_out_right;

  modport master (
    output shift_in, d, OP,
    input  q, shift_out_left, shift_out_right
  );

  modport slave (
    input  shift_in, d, OP,
    output q, shift_out_left, shift_out_right
  );
endinterface

// File: rtl/bidir_shiftreg.sv
// N-bit bidirectional shift register with hold, serial shift left/right and parallel load.
// Serial/parallel conversion element of the PT2262/PT2272 encoder/decoder datapath.
module bidir_shiftreg #(
  parameter int N = 4
) (
  input logic             enable,
  input logic             reset,
  bidir_shiftreg_if.slave bus
);

  typedef enum logic [1:0] {
    OP_HOLD  = 2'b00,
    OP_SHL   = 2'b01,
    OP_SHR   = 2'b10,
    OP_LOAD  = 2'b11
  } op_e;

  logic [N-1:0] q_r;
  logic [N-1:0] q_next;

  // Unknown or unlisted opcodes fall through to the default and keep the contents.
  always_comb begin
    q_next = q_r;
    case (bus.OP)
      OP_HOLD: q_next = q_r;
      OP_SHL:  q_next = {q_r[N-2:0], bus.shift_in};
      OP_SHR:  q_next = {bus.shift_in, q_r[N-1:1]};
      OP_LOAD: q_next = bus.d;
      default: q_next = q_r;
    endcase
  end

  always_ff @(posedge enable or posedge reset) begin
    if (reset) begin
      q_r <= '0;
    end else begin
      q_r <= q_next;
    end
  end

  assign bus.q               = q_r;
  assign bus.shift_out_left  = q_r[N-1];
  assign bus.shift_out_right = q_r[0];

endmodule

// File: tb/tb_bidir_shiftreg.sv
// Directed self-checking bench for bidir_shiftreg (N=4) with hand-computed expectations.
module tb_bidir_shiftreg;

  localparam int N = 4;

  logic enable;
  logic reset;
  int   checks;
  int   failures;

  bidir_shiftreg_if #(.N(N)) bus ();

  bidir_shiftreg #(.N(N)) dut (
    .enable (enable),
    .reset  (reset),
    .bus    (bus.slave)
  );

  initial enable = 1'b0;
  always #5 enable = ~enable;

  // Drive inputs, take one rising edge, then settle before sampling.
  task automatic step(input logic [1:0] op, input logic si, input logic [N-1:0] dv);
    bus.OP       = op;
    bus.shift_in = si;
    bus.d        = dv;
    @(posedge enable);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.OP = 2'b11; bus.d = 4'b1111; bus.shift_in = 1'b1;
    #3;
    checks++;
    if (bus.q !== 4'b0000) begin
      failures++; $display("FAIL reset_q actual=%b required=%b", bus.q, 4'b0000);
    end
    checks++;
    if ({bus.shift_out_left, bus.shift_out_right} !== 2'b00) begin
      failures++; $display("FAIL reset_serial actual=%b required=%b",
                           {bus.shift_out_left, bus.shift_out_right}, 2'b00);
    end
    @(posedge enable); #2;
    reset = 1'b0;
  endtask

  task automatic test_shift_right();
    logic [N-1:0] exp_q [4];
    exp_q = '{4'b0101, 4'b0010, 4'b0001, 4'b0000};
    step(2'b11, 1'b0, 4'b1010);
    checks++;
    if ({bus.q, bus.shift_out_left, bus.shift_out_right} !== {4'b1010, 1'b1, 1'b0}) begin
      failures++; $display("FAIL load_1010 actual=%b/%b%b required=1010/10",
                           bus.q, bus.shift_out_left, bus.shift_out_right);
    end
    for (int i = 0; i < 4; i++) begin
      step(2'b10, 1'b0, 4'b1111);
      checks++;
      if (bus.q !== exp_q[i] || bus.shift_out_right !== exp_q[i][0]) begin
        failures++; $display("FAIL shr_step%0d actual=%b/r%b required=%b/r%b",
                             i, bus.q, bus.shift_out_right, exp_q[i], exp_q[i][0]);
      end
    end
  endtask

  task automatic test_shift_left();
    logic [N-1:0] exp_q [3];
    exp_q = '{4'b0100, 4'b1000, 4'b0000};
    step(2'b11, 1'b0, 4'b1010);
    for (int i = 0; i < 3; i++) begin
      step(2'b01, 1'b0, 4'b1111);
      checks++;
      if (bus.q !== exp_q[i] || bus.shift_out_left !== exp_q[i][N-1]) begin
        failures++; $display("FAIL shl_step%0d actual=%b/l%b required=%b/l%b",
                             i, bus.q, bus.shift_out_left, exp_q[i], exp_q[i][N-1]);
      end
    end
  endtask

  task automatic test_hold();
    step(2'b11, 1'b0, 4'b1111);
    step(2'b00, 1'b1, 4'b0000);
    checks++;
    if ({bus.q, bus.shift_out_left, bus.shift_out_right} !== {4'b1111, 1'b1, 1'b1}) begin
      failures++; $display("FAIL hold actual=%b/%b%b required=1111/11",
                           bus.q, bus.shift_out_left, bus.shift_out_right);
    end
    step(2'bxx, 1'b1, 4'b0000);
    checks++;
    if (bus.q !== 4'b1111) begin
      failures++; $display("FAIL x_op_hold actual=%b required=%b", bus.q, 4'b1111);
    end
  endtask

  task automatic test_drain();
    logic [N-1:0] exp_q [4];
    exp_q = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      step(2'b01, 1'b0, 4'b0101);
      checks++;
      if (bus.q !== exp_q[i] || bus.shift_out_left !== exp_q[i][N-1]) begin
        failures++; $display("FAIL drain_step%0d actual=%b/l%b required=%b/l%b",
                             i, bus.q, bus.shift_out_left, exp_q[i], exp_q[i][N-1]);
      end
    end
    step(2'b01, 1'b0, 4'b0101);
    checks++;
    if (bus.q !== 4'b0000) begin
      failures++; $display("FAIL drain_stays_zero actual=%b required=%b", bus.q, 4'b0000);
    end
  endtask

  task automatic test_serial_fill();
    step(2'b10, 1'b1, 4'b0000);
    checks++;
    if (bus.q !== 4'b1000) begin
      failures++; $display("FAIL fill_shr1 actual=%b required=%b", bus.q, 4'b1000);
    end
    step(2'b10, 1'b1, 4'b0000);
    checks++;
    if (bus.q !== 4'b1100) begin
      failures++; $display("FAIL fill_shr2 actual=%b required=%b", bus.q, 4'b1100);
    end
    step(2'b01, 1'b1, 4'b0000);
    checks++;
    if ({bus.q, bus.shift_out_left, bus.shift_out_right} !== {4'b1001, 1'b1, 1'b1}) begin
      failures++; $display("FAIL fill_shl actual=%b/%b%b required=1001/11",
                           bus.q, bus.shift_out_left, bus.shift_out_right);
    end
  endtask

  task automatic test_async_reset();
    step(2'b11, 1'b0, 4'b1010);
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.q, bus.shift_out_left, bus.shift_out_right} !== 6'b0000_00) begin
      failures++; $display("FAIL async_reset_immediate actual=%b/%b%b required=0000/00",
                           bus.q, bus.shift_out_left, bus.shift_out_right);
    end
    step(2'b11, 1'b1, 4'b1111);
    checks++;
    if (bus.q !== 4'b0000) begin
      failures++; $display("FAIL reset_held_over_edge actual=%b required=%b", bus.q, 4'b0000);
    end
    reset = 1'b0;
    step(2'b11, 1'b0, 4'b0110);
    checks++;
    if (bus.q !== 4'b0110) begin
      failures++; $display("FAIL first_edge_after_reset actual=%b required=%b", bus.q, 4'b0110);
    end
  endtask

  task automatic test_back_to_back();
    step(2'b11, 1'b0, 4'b1001);
    step(2'b10, 1'b1, 4'b0000);
    step(2'b01, 1'b0, 4'b0000);
    step(2'b11, 1'b1, 4'b0011);
    step(2'b10, 1'b0, 4'b1111);
    checks++;
    if (bus.q !== 4'b0001) begin
      failures++; $display("FAIL back_to_back actual=%b required=%b", bus.q, 4'b0001);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_shift_right();
    test_shift_left();
    test_hold();
    test_drain();
    test_serial_fill();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bidir_shiftreg.md
Name: bidir_shiftreg

Overview:
- Parameterizable N-bit bidirectional shift register with parallel load and hold, selected by a 2-bit opcode.
- Serial input shared by both shift directions; both end bits are exposed as serial outputs.
- Used as the serial/parallel conversion element in the PT2262/PT2272 encoder/decoder datapath.

Parameters:
- N, default 4, register width in bits (legal range N >= 2).

Ports:
- enable  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous reset, active-high
- shift_in  input  1  serial data entering the register on either shift
- d  input  N  parallel load data
- OP  input  2  operation select: 00 hold, 01 shift left, 10 shift right, 11 parallel load
- q  output  N  register contents
- shift_out_left  output  1  MSB of register, q[N-1]
- shift_out_right  output  1  LSB of register, q[0]

Behaviour:
- One clock domain. Clock port is enable; reset port is reset. Reset is asynchronous and active-high, exactly as already decided.
- Reset:
  - q clears to all zeros immediately on reset assertion, without waiting for a clock edge.
  - q is held at zero while reset is high, regardless of OP or clock.
  - shift_out_left and shift_out_right therefore read 0 during reset.
  - Asserting reset mid-sequence discards the current contents.
  - First active edge after deassertion executes OP normally.
- On each rising edge of enable, with reset low:
  - OP=00: q holds its value.
  - OP=01: shift left, q <= {q[N-2:0], shift_in}. Old q[N-1] is discarded; shift_in enters at the LSB.
  - OP=10: shift right, q <= {shift_in, q[N-1:1]}. Old q[0] is discarded; shift_in enters at the MSB.
  - OP=11: parallel load, q <= d. shift_in is ignored.
- Serial outputs:
  - Purely combinational from the register: shift_out_left = q[N-1], shift_out_right = q[0].
  - Both reflect the new q right after the edge. There is no extra pipeline stage and no separate output flop.
- Latency: one clock edge from OP/d/shift_in sampled to q updated. Inputs must be stable around the rising edge.
- Inputs are not used outside the clock edge; d is ignored unless OP=11.
- Wrap-around: none. Bits shifted out are lost; repeated shifts with shift_in=0 drain the register to all zeros, after which it stays zero.
- X/unknown OP: treated as hold (q unchanged).
- No enable gating beyond the clock; every edge performs the selected OP.

Test Plan:
- Load then shift right: OP=11, d=1010 -> q=1010, left=1, right=0. Then OP=10, shift_in=0 for four edges -> q=0101/r=1, 0010/r=0, 0001/r=1, 0000/r=0.
- Load then shift left: d=1010 load, then OP=01, shift_in=0 for three edges -> q=0100/l=0, 1000/l=1, 0000/l=0.
- Hold: load 1111, then OP=00 for one edge -> q=1111, left=1, right=1.
- Drain ones leftward: from 1111, OP=01, shift_in=0 for four edges -> 1110, 1100, 1000 (left=1 each), then 0000 (left=0).
- Serial-in fill: from 0000, OP=10 with shift_in=1 for two edges -> 1000 then 1100. Then OP=01 with shift_in=1 for one edge -> 1001.
- Async reset: load 1010, then assert reset between clock edges -> q=0000 immediately, outputs 0. Hold reset across an edge with OP=11 -> q stays 0000. Deassert, next edge with OP=11, d=0110 -> q=0110.
